// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: captures call-button presses into a pending-call
// bitmap and steers the elevator controller with a SCAN (collective) policy.
// The car keeps its direction while calls remain ahead of it, clears a call
// when it stops at that floor, and holds the doors open for a dwell period
// before it picks the next target.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 10,
    parameter int DWELL_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [3:0]            current_floor,
    input  logic                  car_idle,
    output logic [3:0]            requested_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic                  dwell
);

    // A 3-bit encoding leaves spare codes; any of them falls back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_UP   = 3'd1,
        ST_SERVE_DOWN = 3'd2,
        ST_DWELL      = 3'd3
    } state_t;

    localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);

    // Lowest set floor strictly above 'floor'; returns {found, floor}.
    function automatic logic [4:0] find_above(input logic [NUM_FLOORS-1:0] map,
                                              input logic [3:0]            floor);
        logic [4:0] hit;
        hit = 5'd0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            hit = (map[i] && (4'(i) > floor)) ? {1'b1, 4'(i)} : hit;
        end
        return hit;
    endfunction

    // Highest set floor strictly below 'floor'; returns {found, floor}.
    // An off-map 'floor' naturally yields the highest set floor.
    function automatic logic [4:0] find_below(input logic [NUM_FLOORS-1:0] map,
                                              input logic [3:0]            floor);
        logic [4:0] hit;
        hit = 5'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            hit = (map[i] && (4'(i) < floor)) ? {1'b1, 4'(i)} : hit;
        end
        return hit;
    endfunction

    // One-hot mask for a floor; all-zero when the floor is off the map.
    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [3:0] floor);
        logic [NUM_FLOORS-1:0] mask;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            mask[i] = (4'(i) == floor);
        end
        return mask;
    endfunction

    logic [NUM_FLOORS-1:0] btn_q_r;
    logic [NUM_FLOORS-1:0] press_s;
    logic [NUM_FLOORS-1:0] pending_r;
    logic [NUM_FLOORS-1:0] pending_next_s;
    logic [NUM_FLOORS-1:0] clear_mask_s;
    logic [NUM_FLOORS-1:0] cur_mask_s;
    logic                  here_s;
    logic [4:0]            above_hit_s;
    logic [4:0]            below_hit_s;
    logic                  above_ok_s;
    logic                  below_ok_s;
    logic [3:0]            above_floor_s;
    logic [3:0]            below_floor_s;

    state_t                state_r;
    state_t                state_s;
    logic [3:0]            target_r;
    logic [3:0]            target_s;
    logic                  last_up_r;
    logic                  last_up_s;
    logic [15:0]           dwell_cnt_r;
    logic [15:0]           dwell_cnt_s;
    logic                  serve_s;

    logic [3:0]            requested_floor_r;
    logic                  req_valid_r;
    logic                  dir_up_r;
    logic                  dir_down_r;
    logic                  dwell_r;

    // A press is a rising level, so a held button records only one call.
    assign press_s        = call_btn & ~btn_q_r;
    // Clear beats a simultaneous press: the car is already at that floor.
    assign pending_next_s = (pending_r | press_s) & ~clear_mask_s;

    assign cur_mask_s     = floor_mask(current_floor);
    assign here_s         = |(pending_r & cur_mask_s);
    assign above_hit_s    = find_above(pending_r, current_floor);
    assign below_hit_s    = find_below(pending_r, current_floor);
    assign above_ok_s     = above_hit_s[4];
    assign below_ok_s     = below_hit_s[4];
    assign above_floor_s  = above_hit_s[3:0];
    assign below_floor_s  = below_hit_s[3:0];

    assign serve_s = (state_s == ST_SERVE_UP) || (state_s == ST_SERVE_DOWN);

    assign requested_floor = requested_floor_r;
    assign req_valid       = req_valid_r;
    assign pending         = pending_r;
    assign dir_up          = dir_up_r;
    assign dir_down        = dir_down_r;
    assign dwell           = dwell_r;

    // Button history for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q_r <= {NUM_FLOORS{1'b0}};
        end else begin
            btn_q_r <= call_btn;
        end
    end

    // Next-state, target, direction memory, dwell counter and call clearing.
    always_comb begin
        state_s      = state_r;
        target_s     = target_r;
        last_up_s    = last_up_r;
        dwell_cnt_s  = dwell_cnt_r;
        clear_mask_s = {NUM_FLOORS{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (here_s) begin
                    clear_mask_s = cur_mask_s;
                    state_s      = ST_DWELL;
                    dwell_cnt_s  = DWELL_LOAD;
                end else if (above_ok_s) begin
                    state_s   = ST_SERVE_UP;
                    target_s  = above_floor_s;
                    last_up_s = 1'b1;
                end else if (below_ok_s) begin
                    state_s   = ST_SERVE_DOWN;
                    target_s  = below_floor_s;
                    last_up_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE_UP: begin
                last_up_s = 1'b1;
                if (!car_idle) begin
                    // Retarget while moving so new calls ahead are picked up.
                    if (above_ok_s) begin
                        target_s = above_floor_s;
                    end else begin
                        target_s = target_r;
                    end
                end else if (current_floor == target_r) begin
                    clear_mask_s = floor_mask(target_r);
                    state_s      = ST_DWELL;
                    dwell_cnt_s  = DWELL_LOAD;
                end else begin
                    state_s = ST_SERVE_UP;
                end
            end
            ST_SERVE_DOWN: begin
                last_up_s = 1'b0;
                if (!car_idle) begin
                    if (below_ok_s) begin
                        target_s = below_floor_s;
                    end else begin
                        target_s = target_r;
                    end
                end else if (current_floor == target_r) begin
                    clear_mask_s = floor_mask(target_r);
                    state_s      = ST_DWELL;
                    dwell_cnt_s  = DWELL_LOAD;
                end else begin
                    state_s = ST_SERVE_DOWN;
                end
            end
            ST_DWELL: begin
                // Doors are open: presses for this floor are discarded.
                clear_mask_s = cur_mask_s;
                if (dwell_cnt_r == 16'd0) begin
                    if (last_up_r) begin
                        if (above_ok_s) begin
                            state_s   = ST_SERVE_UP;
                            target_s  = above_floor_s;
                            last_up_s = 1'b1;
                        end else if (below_ok_s) begin
                            state_s   = ST_SERVE_DOWN;
                            target_s  = below_floor_s;
                            last_up_s = 1'b0;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        if (below_ok_s) begin
                            state_s   = ST_SERVE_DOWN;
                            target_s  = below_floor_s;
                            last_up_s = 1'b0;
                        end else if (above_ok_s) begin
                            state_s   = ST_SERVE_UP;
                            target_s  = above_floor_s;
                            last_up_s = 1'b1;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                end else begin
                    dwell_cnt_s = dwell_cnt_r - 16'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Scheduler state, pending bitmap and dwell counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            target_r    <= 4'd0;
            last_up_r   <= 1'b1;
            dwell_cnt_r <= 16'd0;
            pending_r   <= {NUM_FLOORS{1'b0}};
        end else begin
            state_r     <= state_s;
            target_r    <= target_s;
            last_up_r   <= last_up_s;
            dwell_cnt_r <= dwell_cnt_s;
            pending_r   <= pending_next_s;
        end
    end

    // Registered outputs, decoded from the state being entered so they
    // change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            requested_floor_r <= 4'd0;
            req_valid_r       <= 1'b0;
            dir_up_r          <= 1'b0;
            dir_down_r        <= 1'b0;
            dwell_r           <= 1'b0;
        end else begin
            // When not serving, mirror the car position so the controller stays put.
            requested_floor_r <= serve_s ? target_s : current_floor;
            req_valid_r       <= serve_s;
            dir_up_r          <= (state_s == ST_SERVE_UP);
            dir_down_r        <= (state_s == ST_SERVE_DOWN);
            dwell_r           <= (state_s == ST_DWELL);
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: a one-floor-per-cycle car model and a
// behavioural SCAN reference model, directed scenarios then random presses.
module tb_elevator_request_scheduler;

    localparam int NF = 10;
    localparam int DW = 4;

    logic          clk;
    logic          reset;
    logic [NF-1:0] call_btn;
    logic [3:0]    current_floor;
    logic          car_idle;
    logic [3:0]    requested_floor;
    logic          req_valid;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          dir_down;
    logic          dwell;

    elevator_request_scheduler #(
        .NUM_FLOORS  (NF),
        .DWELL_CYCLES(DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .call_btn       (call_btn),
        .current_floor  (current_floor),
        .car_idle       (car_idle),
        .requested_floor(requested_floor),
        .req_valid      (req_valid),
        .pending        (pending),
        .dir_up         (dir_up),
        .dir_down       (dir_down),
        .dwell          (dwell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: mode of the car service, travel direction (+1/-1),
    // target floor and remaining dwell cycles (including the current one).
    localparam int M_IDLE  = 0;
    localparam int M_MOVE  = 1;
    localparam int M_DWELL = 2;
    int          m_mode;
    int          m_dir;
    int          m_tgt;
    int          m_left;
    bit [NF-1:0] m_pend;
    bit [NF-1:0] m_btn;
    int          m_rf;
    bit          m_rv, m_up, m_dn, m_dw;
    int          pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("req_valid",       32'(req_valid),       32'(m_rv));
        chk("requested_floor", 32'(requested_floor), 32'(m_rf));
        chk("pending",         32'(pending),         32'(m_pend));
        chk("dir_up",          32'(dir_up),          32'(m_up));
        chk("dir_down",        32'(dir_down),        32'(m_dn));
        chk("dwell",           32'(dwell),           32'(m_dw));
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_dir = 1; m_tgt = 0; m_left = 0;
        m_pend = '0; m_btn = '0;
        m_rf = 0; m_rv = 1'b0; m_up = 1'b0; m_dn = 1'b0; m_dw = 1'b0;
    endtask

    function automatic bit car_idle_calc();
        return !(m_rv && (pos != m_rf));
    endfunction

    // One clock: advance the model from pre-edge inputs, move the car,
    // then compare every output just after the edge.
    task automatic step();
        int ab, be, cur, clr, nxt_pos, first, second;
        bit here, idle_in;
        bit [NF-1:0] press;
        cur     = int'(current_floor);
        idle_in = car_idle;
        press   = call_btn & ~m_btn;
        nxt_pos = pos;
        if (m_rv && pos < m_rf) nxt_pos = pos + 1;
        else if (m_rv && pos > m_rf) nxt_pos = pos - 1;
        ab = -1; be = -1;
        for (int f = NF - 1; f >= 0; f--) if (m_pend[f] && f > cur) ab = f;
        for (int f = 0; f < NF; f++) if (m_pend[f] && f < cur) be = f;
        here = (cur < NF) && m_pend[cur];
        clr  = -1;
        case (m_mode)
            M_IDLE: begin
                if (here) begin
                    clr = cur; m_mode = M_DWELL; m_left = DW;
                end else if (ab >= 0) begin
                    m_mode = M_MOVE; m_dir = 1; m_tgt = ab;
                end else if (be >= 0) begin
                    m_mode = M_MOVE; m_dir = -1; m_tgt = be;
                end
            end
            M_MOVE: begin
                if (!idle_in) begin
                    first = (m_dir > 0) ? ab : be;
                    if (first >= 0) m_tgt = first;
                end else if (cur == m_tgt) begin
                    clr = m_tgt; m_mode = M_DWELL; m_left = DW;
                end
            end
            default: begin
                if (cur < NF) clr = cur;
                if (m_left > 1) begin
                    m_left--;
                end else begin
                    first  = (m_dir > 0) ? ab : be;
                    second = (m_dir > 0) ? be : ab;
                    if (first >= 0) begin
                        m_mode = M_MOVE; m_tgt = first;
                    end else if (second >= 0) begin
                        m_mode = M_MOVE; m_dir = -m_dir; m_tgt = second;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
        endcase
        m_pend = m_pend | press;
        if (clr >= 0) m_pend[clr] = 1'b0;
        m_btn = call_btn;
        m_rv  = (m_mode == M_MOVE);
        m_rf  = m_rv ? m_tgt : cur;
        m_up  = m_rv && (m_dir > 0);
        m_dn  = m_rv && (m_dir < 0);
        m_dw  = (m_mode == M_DWELL);
        @(posedge clk);
        #1;
        pos           = nxt_pos;
        current_floor = 4'(pos);
        car_idle      = car_idle_calc();
        check_outputs();
    endtask

    // Asynchronous reset pulse held across one rising edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        car_idle = car_idle_calc();
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        int rises, nseen, f;
        bit prev_dw, prev_p6, saw_down;
        int seen_floor [3];
        reset = 1'b1; call_btn = '0; pos = 0; current_floor = 4'd0; car_idle = 1'b1;
        model_reset();
        #2;
        check_outputs();
        chk("reset_requested_floor", 32'(requested_floor), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Press 5 from floor 0: pending one edge later, request the next edge.
        call_btn = 10'h020;
        step();
        chk("s1_pending_set", 32'(pending), 32'h020);
        call_btn = '0;
        step();
        chk("s1_req_valid", 32'(req_valid), 32'd1);
        chk("s1_requested", 32'(requested_floor), 32'd5);
        chk("s1_dir_up", 32'(dir_up), 32'd1);
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dwell) rises++;
        end
        chk("s1_dwell_len", 32'(rises), 32'd4);
        chk("s1_idle_pending", 32'(pending), 32'd0);
        chk("s1_idle_valid", 32'(req_valid), 32'd0);

        // Go back to 0, then head for 7 and add 4 on the way.
        call_btn = 10'h001; step(); call_btn = '0;
        for (int i = 0; i < 20; i++) step();
        call_btn = 10'h080; step(); call_btn = '0;
        for (int i = 0; i < 30 && current_floor != 4'd2; i++) step();
        chk("s2_reached_2", 32'(current_floor), 32'd2);
        call_btn = 10'h010; step(); call_btn = '0;
        for (int i = 0; i < 20 && !dwell; i++) step();
        chk("s2_dwell_at_4", 32'(requested_floor), 32'd4);
        chk("s2_pending_7", 32'(pending), 32'h080);
        for (int i = 0; i < DW; i++) step();
        chk("s2_resume_valid", 32'(req_valid), 32'd1);
        chk("s2_resume_target", 32'(requested_floor), 32'd7);

        // Calls at 8 and 1 while heading up: serve 7, 8, then down to 1.
        call_btn = 10'h102; step(); call_btn = '0;
        nseen = 0; prev_dw = dwell; saw_down = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (dwell && !prev_dw && nseen < 3) begin
                seen_floor[nseen] = int'(requested_floor);
                nseen++;
            end
            if (dir_down && req_valid) saw_down = 1'b1;
            prev_dw = dwell;
        end
        chk("s3_stops", 32'(nseen), 32'd3);
        chk("s3_stop0", 32'(seen_floor[0]), 32'd7);
        chk("s3_stop1", 32'(seen_floor[1]), 32'd8);
        chk("s3_stop2", 32'(seen_floor[2]), 32'd1);
        chk("s3_dir_down", 32'(saw_down), 32'd1);

        // Call at the floor where the car stands: straight to dwell.
        f = int'(current_floor);
        call_btn = '0; call_btn[f] = 1'b1; step(); call_btn = '0;
        step();
        chk("s4_dwell", 32'(dwell), 32'd1);
        chk("s4_no_valid", 32'(req_valid), 32'd0);
        chk("s4_cleared", 32'(pending), 32'd0);
        step();
        call_btn[f] = 1'b1; step(); call_btn = '0;
        chk("s4_discard", 32'(pending), 32'd0);
        for (int i = 0; i < 10; i++) step();

        // Held button records exactly one call and does not re-arm.
        rises = 0; prev_p6 = pending[6];
        call_btn = 10'h040;
        for (int i = 0; i < 50; i++) begin
            step();
            if (pending[6] && !prev_p6) rises++;
            prev_p6 = pending[6];
        end
        chk("s5_one_press", 32'(rises), 32'd1);
        chk("s5_still_clear", 32'(pending[6]), 32'd0);
        call_btn = '0;
        for (int i = 0; i < 5; i++) step();

        // Reset mid-trip, then serve a fresh call.
        call_btn = 10'h204; step(); call_btn = '0;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        #1;
        chk("s6_pending", 32'(pending), 32'd0);
        chk("s6_valid", 32'(req_valid), 32'd0);
        chk("s6_requested", 32'(requested_floor), 32'd0);
        chk("s6_dir_up", 32'(dir_up), 32'd0);
        model_reset();
        car_idle = car_idle_calc();
        @(posedge clk); #1;
        reset = 1'b0;
        check_outputs();
        call_btn = 10'h002; step(); call_btn = '0;
        for (int i = 0; i < 30 && !dwell; i++) step();
        chk("s6_served_1", 32'(dwell), 32'd1);
        chk("s6_floor_1", 32'(requested_floor), 32'd1);

        // Random presses with occasional resets.
        for (int i = 0; i < 800; i++) begin
            call_btn = NF'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
